dlx_decode_stage: RTL

//  Registered DLX instruction decode (ID->EX) stage: the producer of the ALU op code (I[4:0])
//  and operand controls consumed by the EX-stage ALU. Decodes R/I/J-type words, builds the

---
 rtl/dlx_decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dlx_decode_stage.sv
// DLX instruction decode stage: decodes R/I/J words into ALU/operand controls and
// registers them into the ID/EX register with load-use, stall and flush handling.
module dlx_decode_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [4:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_use_imm,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_reg_wr,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_illegal
);

    logic [5:0] op;
    logic [5:0] func;
    logic       is_r;
    logic [DATA_W-1:0] imm_s16, imm_z16, imm_s26;

    assign op      = if_instr[31:26];
    assign func    = if_instr[5:0];
    assign is_r    = (op == 6'h00);
    assign imm_s16 = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
    assign imm_z16 = {{(DATA_W-16){1'b0}}, if_instr[15:0]};
    assign imm_s26 = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};

    logic [4:0]        alu_op_d;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic [DATA_W-1:0] imm_d;
    logic use_imm_d, mem_rd_d, mem_wr_d, reg_wr_d, branch_d, jump_d, illegal_d;
    logic legal, wr_rd, link;

    always_comb begin
        legal     = 1'b1;
        wr_rd     = 1'b0;
        link      = 1'b0;
        alu_op_d  = 5'd1;
        rs1_d     = REG_AW'(if_instr[25:21]);
        rs2_d     = REG_AW'(if_instr[20:16]);
        rd_d      = REG_AW'(if_instr[20:16]);
        imm_d     = imm_s16;
        use_imm_d = !is_r;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        reg_wr_d  = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 1'b0;
        illegal_d = 1'b0;
        if (is_r) begin
            rd_d  = REG_AW'(if_instr[15:11]);
            imm_d = '0;
            wr_rd = 1'b1;
            case (func)
                6'h20: alu_op_d = 5'd1;
                6'h22: alu_op_d = 5'd2;
                6'h24: alu_op_d = 5'd3;
                6'h25: alu_op_d = 5'd4;
                6'h26: alu_op_d = 5'd5;
                6'h04: alu_op_d = 5'd6;
                6'h06: alu_op_d = 5'd7;
                6'h07: alu_op_d = 5'd14;
                6'h28: alu_op_d = 5'd10;
                6'h29: alu_op_d = 5'd13;
                6'h2A: alu_op_d = 5'd12;
                6'h2C: alu_op_d = 5'd11;
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin alu_op_d = 5'd1;  wr_rd = 1'b1; end
                6'h0A: begin alu_op_d = 5'd2;  wr_rd = 1'b1; end
                6'h0C: begin alu_op_d = 5'd3;  wr_rd = 1'b1; imm_d = imm_z16; end
                6'h0D: begin alu_op_d = 5'd4;  wr_rd = 1'b1; imm_d = imm_z16; end
                6'h0E: begin alu_op_d = 5'd5;  wr_rd = 1'b1; imm_d = imm_z16; end
                // LHI passes the raw half-word; the ALU does the shift into the upper half
                6'h0F: begin alu_op_d = 5'd0;  wr_rd = 1'b1; imm_d = imm_z16; end
                6'h14: begin alu_op_d = 5'd6;  wr_rd = 1'b1; end
                6'h16: begin alu_op_d = 5'd7;  wr_rd = 1'b1; end
                6'h17: begin alu_op_d = 5'd14; wr_rd = 1'b1; end
                6'h18: begin alu_op_d = 5'd10; wr_rd = 1'b1; end
                6'h19: begin alu_op_d = 5'd13; wr_rd = 1'b1; end
                6'h1A: begin alu_op_d = 5'd12; wr_rd = 1'b1; end
                6'h1C: begin alu_op_d = 5'd11; wr_rd = 1'b1; end
                6'h23: begin alu_op_d = 5'd1;  wr_rd = 1'b1; mem_rd_d = 1'b1; end
                6'h2B: begin alu_op_d = 5'd1;  mem_wr_d = 1'b1; end
                6'h04: begin alu_op_d = 5'd8;  branch_d = 1'b1; end
                6'h05: begin alu_op_d = 5'd9;  branch_d = 1'b1; end
                6'h02: begin alu_op_d = 5'd1;  jump_d = 1'b1; imm_d = imm_s26; end
                6'h03: begin alu_op_d = 5'd15; jump_d = 1'b1; imm_d = imm_s26; link = 1'b1; end
                6'h12: begin alu_op_d = 5'd1;  jump_d = 1'b1; end
                6'h13: begin alu_op_d = 5'd15; jump_d = 1'b1; link = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            alu_op_d  = 5'd1;
            illegal_d = 1'b1;
            use_imm_d = 1'b0;
            imm_d     = '0;
            mem_rd_d  = 1'b0;
            mem_wr_d  = 1'b0;
            branch_d  = 1'b0;
            jump_d    = 1'b0;
        end else if (link) begin
            rd_d     = REG_AW'(5'd31);
            reg_wr_d = 1'b1;
        end else begin
            reg_wr_d = wr_rd && (rd_d != '0);
        end
    end

    logic uses_rs2, hazard;
    assign uses_rs2 = is_r || (op == 6'h2B);
    // Only a load sitting in EX can produce this hazard; forwarding covers the rest
    assign hazard   = HAZARD_EN && if_valid && ex_valid && ex_mem_rd && (ex_rd != '0) &&
                      ((ex_rd == rs1_d) || (uses_rs2 && (ex_rd == rs2_d)));
    assign id_ready = !ex_stall && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_alu_op  <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
            ex_use_imm <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_reg_wr  <= 1'b0;
            ex_branch  <= 1'b0;
            ex_jump    <= 1'b0;
            ex_pc      <= '0;
            ex_illegal <= 1'b0;
        end else if (flush || (!ex_stall && (hazard || !if_valid))) begin
            // Bubble: flush wins over stall; data fields are left as don't-care
            ex_valid   <= 1'b0;
            ex_use_imm <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_reg_wr  <= 1'b0;
            ex_branch  <= 1'b0;
            ex_jump    <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid   <= 1'b1;
            ex_alu_op  <= alu_op_d;
            ex_rs1     <= rs1_d;
            ex_rs2     <= rs2_d;
            ex_rd      <= rd_d;
            ex_imm     <= imm_d;
            ex_use_imm <= use_imm_d;
            ex_mem_rd  <= mem_rd_d;
            ex_mem_wr  <= mem_wr_d;
            ex_reg_wr  <= reg_wr_d;
            ex_branch  <= branch_d;
            ex_jump    <= jump_d;
            ex_pc      <= if_pc;
            ex_illegal <= illegal_d;
        end
    end

endmodule
